button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Input front-end that feeds the game top level's btn_left, btn_right and btn_select from raw board pins. It synchronises each asynchronous pin, debounces it, and produces a clean level per button. It also produces single-cycle press/release pulses, with frame-timed auto-repeat on selected buttons so game_logic sees steady paddle steps. It sits between the I/O pads and breakout, and is timed by the VGA frame_pulse.

Parameters:
NUM_BTN, 3, number of buttons; bit 0 = left, 1 = right, 2 = select.
DEBOUNCE_BITS, 16, debounce counter width; a change must persist 2^DEBOUNCE_BITS cycles.
REPEAT_DELAY, 20, frames a button is held before the first auto-repeat press (range 1..255).
REPEAT_RATE, 4, frames between subsequent auto-repeat presses (range 1..255).
REPEAT_MASK, 3'b011, per-button auto-repeat enable.

Ports:
clk  in  1  pixel clock, the clock used throughout the codebase.
nRst  in  1  reset; synchronous, active-low.
en  in  1  global enable.
frame_pulse  in  1  one-cycle pulse per video frame, from vga_timing.
btn_raw  in  NUM_BTN  asynchronous raw pin levels, active-high.
btn_level  out  NUM_BTN  debounced level.
btn_press  out  NUM_BTN  one-cycle pulse: debounced rising edge or auto-repeat.
btn_release  out  NUM_BTN  one-cycle pulse: debounced falling edge.

Behaviour:
- Reset: this single clock domain uses one clock, and the reset is synchronous and active-low (nRst=0 sampled on a clk edge).
  - During reset: all sync flops, debounce counters, btn_level, btn_press, btn_release, frame counters and FSMs go to 0 / IDLE.
  - Asserting reset mid-debounce or mid-repeat discards that progress; no pulse is emitted.
- Synchroniser: a 2-flop chain per button that runs every cycle regardless of en. The output is sync[i].
- Debounce, per button, only while en=1:
  - sync[i]==btn_level[i] -> counter cleared.
  - Mismatch -> counter increments.
  - Mismatch with counter at all-ones -> btn_level toggles and the counter is cleared.
  - Result: level changes exactly 2 + 2^DEBOUNCE_BITS cycles after a clean raw edge.
  - Any glitch that returns to the old level before then restarts the count from 0.
- Edge pulses are registered and asserted in the same cycle btn_level changes:
  - rising edge -> btn_press[i]=1;
  - falling edge -> btn_release[i]=1.
  - Pulses are exactly 1 cycle wide.
- Auto-repeat FSM, per button with REPEAT_MASK[i]=1. It uses an 8-bit frame counter fcnt.
  - IDLE: on debounced rise -> DELAY, fcnt=0.
  - DELAY: each frame_pulse increments fcnt. At fcnt reaching REPEAT_DELAY: press pulse, go to REPEAT, fcnt=0.
  - REPEAT: each frame_pulse increments fcnt. At fcnt reaching REPEAT_RATE: press pulse, fcnt=0.
  - DELAY/REPEAT: on debounced fall -> IDLE, release pulse.
- Buttons with REPEAT_MASK[i]=0 stay in IDLE; they give one press per physical press.
- Simultaneous events:
  - A debounced rise and a frame_pulse in the same cycle: the press pulse is emitted and that frame_pulse is not counted (fcnt stays 0).
  - A debounced fall and a repeat-due frame_pulse in the same cycle: the release pulse is emitted and the press is suppressed.
- Buttons are fully independent; presses on several buttons in the same cycle are allowed.
- en=0:
  - debounce counters, btn_level, FSM state and fcnt hold;
  - frame_pulse is ignored;
  - btn_press and btn_release are forced 0.
  - When en returns to 1, operation resumes from the held state with no catch-up pulses.
- Width rules:
  - the debounce counter wraps only via an explicit clear;
  - fcnt compares with ==;
  - an implementation that lets fcnt exceed its target is non-compliant.

Decomposition:
- Shared package holds the button index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_SELECT=2) and the repeat FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2).
- One natural sub-module, btn_channel: synchroniser, debounce, edge and repeat logic for a single button.
- The top instantiates btn_channel NUM_BTN times via generate and passes REPEAT_MASK[i] as a parameter.

Test Plan:
All scenarios use DEBOUNCE_BITS=3, REPEAT_DELAY=3, REPEAT_RATE=2, and a frame_pulse every 20 cycles.
- Clean press: btn_raw[0] rises at cycle 0 -> btn_level[0]=1 and btn_press[0]=1 at cycle 10 (press for one cycle only); btn_release stays 0.
- Bounce: btn_raw[1] toggles 1,0,1 with 5-cycle high/low phases, then holds 1 -> exactly one btn_press[1], 10 cycles after the final rise.
- Auto-repeat: hold btn_raw[0] for 200 cycles -> first press at the debounce point, then further presses after the 3rd frame_pulse and every 2nd frame_pulse after that; after the release debounces -> one btn_release[0] and no further presses.
- No-repeat select: hold btn_raw[2] for 200 cycles -> exactly one btn_press[2].
- Enable freeze: drop en mid-debounce for 30 cycles -> btn_level, btn_press and btn_release unchanged during the gap; btn_level rises once en=1 has been high for the remaining count.
- Reset mid-repeat: nRst=0 for 1 cycle while in REPEAT -> all outputs 0 next cycle. A still-held raw button re-debounces and produces a fresh press 10 cycles after reset release.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared button indices and auto-repeat state encoding for the button front-end.
// Pure definitions; no logic, no timing.
package button_conditioner_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_SELECT = 2;

    localparam int FCNT_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button: 2-flop sync, debounce, registered press/release pulses, frame-timed auto-repeat.
// Level and edge pulses appear 2 + 2^DEBOUNCE_BITS cycles after a clean raw edge; no backpressure, en freezes all state.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_RATE   = 4,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic frame_pulse,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [FCNT_BITS-1:0]     DELAY_TGT = FCNT_BITS'(REPEAT_DELAY);
    localparam logic [FCNT_BITS-1:0]     RATE_TGT  = FCNT_BITS'(REPEAT_RATE);
    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX   = '1;
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE   = DEBOUNCE_BITS'(1);

    logic [1:0]               sync_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     press_q, press_d;
    logic                     release_q, release_d;
    rpt_state_e               state_q, state_d;
    logic [FCNT_BITS-1:0]     fcnt_q, fcnt_d;
    logic [FCNT_BITS-1:0]     fcnt_inc;
    logic                     rise, fall, rpt_press;

    // Synchroniser keeps running while en=0 so the pin is never stale on resume.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (en) begin
            if (sync_q[1] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // A fall always wins over a due repeat; a rise never counts the coincident frame.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        rpt_press = 1'b0;
        fcnt_inc  = fcnt_q + FCNT_BITS'(1);
        if (en && REPEAT_EN) begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = DELAY;
                        fcnt_d  = '0;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else if (frame_pulse) begin
                        if (fcnt_inc == DELAY_TGT) begin
                            rpt_press = 1'b1;
                            state_d   = REPEAT;
                            fcnt_d    = '0;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else if (frame_pulse) begin
                        if (fcnt_inc == RATE_TGT) begin
                            rpt_press = 1'b1;
                            fcnt_d    = '0;
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        press_d   = en & (rise | rpt_press);
        release_d = en & fall;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
            fcnt_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q & en;
    assign release_o = release_q & en;

endmodule

// File: rtl/button_conditioner.sv
// Raw-pin front-end for the game: per-button sync/debounce with press, release and auto-repeat pulses.
// Outputs lag a clean raw edge by 2 + 2^DEBOUNCE_BITS cycles; no backpressure, en=0 freezes and silences pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                 NUM_BTN       = 3,
    parameter int                 DEBOUNCE_BITS = 16,
    parameter int                 REPEAT_DELAY  = 20,
    parameter int                 REPEAT_RATE   = 4,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 3'b011
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic               frame_pulse,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_BITS (DEBOUNCE_BITS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk         (clk),
            .nRst        (nRst),
            .en          (en),
            .frame_pulse (frame_pulse),
            .raw_i       (btn_raw[i]),
            .level_o     (btn_level[i]),
            .press_o     (btn_press[i]),
            .release_o   (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: driver pushes expected outputs from a behavioural model, monitor pops and compares.
module tb_button_conditioner;

    localparam int DB = 3;
    localparam int RD = 3;
    localparam int RR = 2;
    localparam logic [2:0] MASK = 3'b011;

    logic       clk = 1'b0;
    logic       nRst, en, frame_pulse;
    logic [2:0] btn_raw, btn_level, btn_press, btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN       (3),
        .DEBOUNCE_BITS (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .en          (en),
        .frame_pulse (frame_pulse),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    typedef struct {
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic [2:0] raw_cur = 3'b000;

    // Reference model: raw seen two samples late, level flips after 2^DB consecutive
    // enabled mismatching samples, repeat presses counted in frames since the debounced press.
    logic [2:0] m_pipe[$] = '{3'b000, 3'b000};
    logic [2:0] m_lvl = 3'b000;
    int         m_run[3];
    bit         m_held[3];
    int         m_frames[3];
    int         m_target[3];

    task automatic step(input logic r_n, input logic e, input logic [2:0] raw);
        logic [2:0] seen, prs, rel;
        exp_t x;
        @(negedge clk);
        nRst        = r_n;
        en          = e;
        btn_raw     = raw;
        frame_pulse = (cyc % 20 == 19);
        prs = 3'b000;
        rel = 3'b000;
        if (!r_n) begin
            m_pipe = '{3'b000, 3'b000};
            m_lvl  = 3'b000;
            for (int b = 0; b < 3; b++) begin
                m_run[b] = 0; m_held[b] = 0; m_frames[b] = 0; m_target[b] = 0;
            end
        end else begin
            seen = m_pipe.pop_front();
            m_pipe.push_back(raw);
            if (e) begin
                for (int b = 0; b < 3; b++) begin
                    bit edge_now;
                    edge_now = 0;
                    if (seen[b] != m_lvl[b]) begin
                        m_run[b]++;
                        if (m_run[b] == (1 << DB)) begin
                            m_run[b] = 0;
                            m_lvl[b] = ~m_lvl[b];
                            edge_now = 1;
                            if (m_lvl[b]) begin
                                prs[b] = 1'b1;
                                if (MASK[b]) begin
                                    m_held[b] = 1; m_frames[b] = 0; m_target[b] = RD;
                                end
                            end else begin
                                rel[b] = 1'b1;
                                m_held[b] = 0;
                            end
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    if (!edge_now && m_held[b] && frame_pulse) begin
                        m_frames[b]++;
                        if (m_frames[b] == m_target[b]) begin
                            prs[b] = 1'b1;
                            m_frames[b] = 0;
                            m_target[b] = RR;
                        end
                    end
                end
            end
        end
        x.lvl = m_lvl;
        x.prs = prs;
        x.rel = rel;
        x.cyc = cyc;
        exp_q.push_back(x);
        cyc++;
    endtask

    task automatic run(input int n, input logic r_n, input logic e);
        repeat (n) step(r_n, e, raw_cur);
    endtask

    task automatic align(input int phase);
        while (cyc % 20 != phase) step(1'b1, 1'b1, raw_cur);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (btn_level !== x.lvl || btn_press !== x.prs || btn_release !== x.rel) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got lvl/prs/rel=%b/%b/%b expected %b/%b/%b",
                         x.cyc, btn_level, btn_press, btn_release, x.lvl, x.prs, x.rel);
            end
        end
    end

    initial begin
        int   len;
        bit   noisy;
        logic seg_en;
        nRst        = 1'b0;
        en          = 1'b1;
        frame_pulse = 1'b0;
        btn_raw     = 3'b000;

        run(4, 1'b0, 1'b1);
        run(5, 1'b1, 1'b1);

        // clean press with auto-repeat on left, then release
        raw_cur[0] = 1'b1; run(200, 1'b1, 1'b1);
        raw_cur[0] = 1'b0; run(30, 1'b1, 1'b1);

        // bouncing right button
        raw_cur[1] = 1'b1; run(5, 1'b1, 1'b1);
        raw_cur[1] = 1'b0; run(5, 1'b1, 1'b1);
        raw_cur[1] = 1'b1; run(40, 1'b1, 1'b1);
        raw_cur[1] = 1'b0; run(30, 1'b1, 1'b1);

        // select has no auto-repeat
        raw_cur[2] = 1'b1; run(200, 1'b1, 1'b1);
        raw_cur[2] = 1'b0; run(30, 1'b1, 1'b1);

        // enable dropped mid-debounce
        raw_cur[1] = 1'b1; run(5, 1'b1, 1'b1);
        run(30, 1'b1, 1'b0);
        run(30, 1'b1, 1'b1);
        raw_cur[1] = 1'b0; run(20, 1'b1, 1'b1);

        // reset while repeating, button still held
        raw_cur[0] = 1'b1; run(120, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1);
        run(30, 1'b1, 1'b1);
        raw_cur[0] = 1'b0; run(30, 1'b1, 1'b1);

        // rise lands on a frame pulse; fall lands on a repeat-due frame pulse
        align(10);
        raw_cur[0] = 1'b1; run(140, 1'b1, 1'b1);
        raw_cur[0] = 1'b0; run(30, 1'b1, 1'b1);

        for (int s = 0; s < 60; s++) begin
            len    = $urandom_range(10, 150);
            noisy  = ($urandom_range(0, 3) == 0);
            seg_en = ($urandom_range(0, 5) != 0);
            raw_cur = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) run(1, 1'b0, 1'b1);
            for (int k = 0; k < len; k++) begin
                if (noisy) begin
                    for (int b = 0; b < 3; b++)
                        if ($urandom_range(0, 7) == 0) raw_cur[b] = ~raw_cur[b];
                end
                step(1'b1, seg_en, raw_cur);
            end
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
